// File: rtl/picorv32_freeahb_pkg.sv
// Shared encodings for the PicoRV32 to FreeAHB bridge: transfer sizes,
// protection codes, controller states and the error read value.
package picorv32_freeahb_pkg;

   localparam logic [2:0] SIZE_BYTE = 3'b000;
   localparam logic [2:0] SIZE_HALF = 3'b001;
   localparam logic [2:0] SIZE_WORD = 3'b010;

   localparam logic [3:0] PROT_INSTR = 4'b0000;
   localparam logic [3:0] PROT_DATA  = 4'b0001;

   localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_ISSUE,
      WR_DRAIN,
      DONE,
      HOLD
   } bridge_state_t;

   // FreeAHB wants the transfer length in bits alongside the size code.
   function automatic logic [31:0] len_for_size(input logic [2:0] size);
      case (size)
         SIZE_BYTE: return 32'd8;
         SIZE_HALF: return 32'd16;
         default:   return 32'd32;
      endcase
   endfunction

   // Lowest byte lane present in a lane mask; used to right-align piece data.
   function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
      logic [1:0] lane;
      lane = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) lane = 2'(i);
      end
      return lane;
   endfunction

endpackage

// File: rtl/picorv32_wstrb_splitter.sv
// Breaks a PicoRV32 write strobe into naturally aligned FreeAHB pieces,
// listed in ascending address order, and describes the selected piece.
module picorv32_wstrb_splitter
   import picorv32_freeahb_pkg::*;
#(
   parameter int unsigned BIG_ENDIAN    = 1,
   parameter int unsigned MERGE_STROBES = 1
) (
   input  logic [3:0] wstrb,
   input  logic [1:0] piece,
   output logic [1:0] offset,
   output logic [2:0] size,
   output logic [3:0] lane_mask,
   output logic       last
);

   logic [3:0] amask;
   logic [3:0] amask_piece;
   logic [1:0] p_off  [4];
   logic [2:0] p_size [4];
   logic [2:0] count;

   // Reorder strobes into address order, then build the piece list.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         amask[k] = (BIG_ENDIAN != 0) ? wstrb[3-k] : wstrb[k];
      end
      count = 3'd0;
      for (int i = 0; i < 4; i++) begin
         p_off[i]  = 2'd0;
         p_size[i] = SIZE_BYTE;
      end
      if ((MERGE_STROBES != 0) && (amask == 4'hF)) begin
         p_size[0] = SIZE_WORD;
         count     = 3'd1;
      end else begin
         for (int h = 0; h < 2; h++) begin
            if ((MERGE_STROBES != 0) && amask[2*h] && amask[2*h+1]) begin
               p_off[count[1:0]]  = 2'(2*h);
               p_size[count[1:0]] = SIZE_HALF;
               count              = count + 3'd1;
            end else begin
               for (int b = 0; b < 2; b++) begin
                  if (amask[2*h+b]) begin
                     p_off[count[1:0]]  = 2'(2*h+b);
                     p_size[count[1:0]] = SIZE_BYTE;
                     count              = count + 3'd1;
                  end
               end
            end
         end
      end
   end

   // Describe the requested piece and map its bytes back onto data lanes.
   always_comb begin
      offset = p_off[piece];
      size   = p_size[piece];
      last   = ((3'(piece) + 3'd1) == count);
      case (size)
         SIZE_WORD: amask_piece = 4'hF;
         SIZE_HALF: amask_piece = 4'b0011 << offset;
         default:   amask_piece = 4'b0001 << offset;
      endcase
      for (int k = 0; k < 4; k++) begin
         lane_mask[k] = (BIG_ENDIAN != 0) ? amask_piece[3-k] : amask_piece[k];
      end
   end

endmodule

// File: rtl/picorv32_freeahb_bridge.sv
// Converts PicoRV32 native memory requests into FreeAHB master transfers,
// splitting partial writes into aligned pieces and holding off the core
// for a fixed number of cycles after each completion.
module picorv32_freeahb_bridge
   import picorv32_freeahb_pkg::*;
#(
   parameter int unsigned BIG_ENDIAN     = 1,
   parameter int unsigned MERGE_STROBES  = 1,
   parameter int unsigned WDATA_RALIGN   = 0,
   parameter int unsigned HOLD_CYCLES    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic [31:0] freeahb_wdata,
   output logic        freeahb_valid,
   output logic [31:0] freeahb_addr,
   output logic [2:0]  freeahb_size,
   output logic        freeahb_write,
   output logic        freeahb_read,
   output logic [31:0] freeahb_min_len,
   output logic        freeahb_cont,
   output logic [3:0]  freeahb_prot,
   output logic        freeahb_lock,
   input  logic        freeahb_next,
   input  logic [31:0] freeahb_rdata,
   input  logic        freeahb_ready,
   output logic        bus_err
);

   bridge_state_t state, state_next;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        instr_q;
   logic [1:0]  piece_idx;
   logic [31:0] cnt;

   logic [1:0]  pc_offset;
   logic [2:0]  pc_size;
   logic [3:0]  pc_lane_mask;
   logic        pc_last;
   logic [31:0] lane_bits;

   logic        timeout_due;
   logic        accept_req;
   logic        piece_done;
   logic        take_rdata;
   logic        timeout_take;

   assign freeahb_cont = 1'b0;
   assign freeahb_lock = 1'b0;
   assign timeout_due  = (TIMEOUT_CYCLES != 0) && (cnt == (TIMEOUT_CYCLES - 1));

   picorv32_wstrb_splitter #(
      .BIG_ENDIAN    (BIG_ENDIAN),
      .MERGE_STROBES (MERGE_STROBES)
   ) u_splitter (
      .wstrb     (wstrb_q),
      .piece     (piece_idx),
      .offset    (pc_offset),
      .size      (pc_size),
      .lane_mask (pc_lane_mask),
      .last      (pc_last)
   );

   // State register; reset abandons any transfer in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode and FreeAHB/PicoRV32 handshake outputs.
   always_comb begin
      state_next      = state;
      mem_ready       = 1'b0;
      freeahb_valid   = 1'b0;
      freeahb_read    = 1'b0;
      freeahb_write   = 1'b0;
      freeahb_addr    = 32'd0;
      freeahb_size    = SIZE_WORD;
      freeahb_min_len = 32'd0;
      freeahb_wdata   = 32'd0;
      freeahb_prot    = PROT_DATA;
      accept_req      = 1'b0;
      piece_done      = 1'b0;
      take_rdata      = 1'b0;
      timeout_take    = 1'b0;
      for (int k = 0; k < 4; k++) lane_bits[8*k +: 8] = {8{pc_lane_mask[k]}};

      case (state)
         IDLE: begin
            if (mem_valid) begin
               accept_req = 1'b1;
               state_next = (mem_wstrb == 4'd0) ? RD_REQ : WR_ISSUE;
            end
         end
         RD_REQ: begin
            freeahb_valid   = 1'b1;
            freeahb_read    = 1'b1;
            freeahb_addr    = addr_q;
            freeahb_min_len = len_for_size(SIZE_WORD);
            freeahb_prot    = instr_q ? PROT_INSTR : PROT_DATA;
            if (freeahb_next) begin
               state_next = RD_WAIT;
            end else if (timeout_due) begin
               timeout_take = 1'b1;
               state_next   = DONE;
            end
         end
         RD_WAIT: begin
            freeahb_prot = instr_q ? PROT_INSTR : PROT_DATA;
            if (freeahb_ready) begin
               take_rdata = 1'b1;
               state_next = DONE;
            end else if (timeout_due) begin
               timeout_take = 1'b1;
               state_next   = DONE;
            end
         end
         WR_ISSUE: begin
            freeahb_valid   = 1'b1;
            freeahb_write   = 1'b1;
            freeahb_addr    = {addr_q[31:2], pc_offset};
            freeahb_size    = pc_size;
            freeahb_min_len = len_for_size(pc_size);
            freeahb_prot    = instr_q ? PROT_INSTR : PROT_DATA;
            freeahb_wdata   = (WDATA_RALIGN != 0)
                              ? ((wdata_q & lane_bits) >> {lowest_lane(pc_lane_mask), 3'b000})
                              : wdata_q;
            if (freeahb_next) begin
               piece_done = 1'b1;
               if (pc_last) state_next = WR_DRAIN;
            end else if (timeout_due) begin
               timeout_take = 1'b1;
               state_next   = DONE;
            end
         end
         WR_DRAIN: begin
            freeahb_prot = instr_q ? PROT_INSTR : PROT_DATA;
            if (freeahb_next) begin
               state_next = DONE;
            end else if (timeout_due) begin
               timeout_take = 1'b1;
               state_next   = DONE;
            end
         end
         DONE: begin
            mem_ready  = 1'b1;
            state_next = HOLD;
         end
         HOLD: begin
            if (cnt == (HOLD_CYCLES - 1)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, piece index, dwell counter, read data and error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         instr_q   <= 1'b0;
         piece_idx <= 2'd0;
         cnt       <= 32'd0;
         mem_rdata <= 32'd0;
         bus_err   <= 1'b0;
      end else begin
         if (accept_req) begin
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            wstrb_q   <= mem_wstrb;
            instr_q   <= mem_instr;
            piece_idx <= 2'd0;
         end else if (piece_done && !pc_last) begin
            piece_idx <= piece_idx + 2'd1;
         end
         if ((state_next != state) || piece_done) cnt <= 32'd0;
         else if (cnt != 32'hFFFF_FFFF)           cnt <= cnt + 32'd1;
         if (take_rdata) mem_rdata <= freeahb_rdata;
         if (timeout_take) begin
            mem_rdata <= ERR_RDATA;
            bus_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_picorv32_freeahb_bridge.sv
// Directed bench for the PicoRV32 to FreeAHB bridge. Two instances: one with
// default parameters, one with strobe merging off and an 8-cycle timeout.
module tb_picorv32_freeahb_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sel = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [3:0]  mem_wstrb = 4'd0;
   logic        next_drv = 1'b0;
   logic [31:0] freeahb_rdata = 32'd0;
   logic        freeahb_ready = 1'b0;

   logic        a_valid_in, a_next_in, b_valid_in, b_next_in;
   logic        a_mem_ready, b_mem_ready, a_fvalid, b_fvalid;
   logic        a_fwrite, b_fwrite, a_fread, b_fread;
   logic        a_fcont, b_fcont, a_flock, b_flock, a_bus_err, b_bus_err;
   logic [31:0] a_mem_rdata, b_mem_rdata, a_fwdata, b_fwdata;
   logic [31:0] a_faddr, b_faddr, a_fmin_len, b_fmin_len;
   logic [2:0]  a_fsize, b_fsize;
   logic [3:0]  a_fprot, b_fprot;

   logic        obs_mem_ready, obs_valid, obs_write, obs_read, obs_bus_err;
   logic [31:0] obs_mem_rdata, obs_wdata, obs_addr, obs_min_len;
   logic [2:0]  obs_size;
   logic [3:0]  obs_prot;

   int vectors = 0;
   int miscompares = 0;

   assign a_valid_in = mem_valid & ~sel;
   assign a_next_in  = next_drv & ~sel;
   assign b_valid_in = mem_valid & sel;
   assign b_next_in  = next_drv & sel;

   assign obs_mem_ready = sel ? b_mem_ready : a_mem_ready;
   assign obs_valid     = sel ? b_fvalid    : a_fvalid;
   assign obs_write     = sel ? b_fwrite    : a_fwrite;
   assign obs_read      = sel ? b_fread     : a_fread;
   assign obs_bus_err   = sel ? b_bus_err   : a_bus_err;
   assign obs_mem_rdata = sel ? b_mem_rdata : a_mem_rdata;
   assign obs_wdata     = sel ? b_fwdata    : a_fwdata;
   assign obs_addr      = sel ? b_faddr     : a_faddr;
   assign obs_min_len   = sel ? b_fmin_len  : a_fmin_len;
   assign obs_size      = sel ? b_fsize     : a_fsize;
   assign obs_prot      = sel ? b_fprot     : a_fprot;

   picorv32_freeahb_bridge dut_a (
      .clk (clk), .reset (reset),
      .mem_valid (a_valid_in), .mem_instr (mem_instr), .mem_ready (a_mem_ready),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_wstrb (mem_wstrb),
      .mem_rdata (a_mem_rdata), .freeahb_wdata (a_fwdata), .freeahb_valid (a_fvalid),
      .freeahb_addr (a_faddr), .freeahb_size (a_fsize), .freeahb_write (a_fwrite),
      .freeahb_read (a_fread), .freeahb_min_len (a_fmin_len), .freeahb_cont (a_fcont),
      .freeahb_prot (a_fprot), .freeahb_lock (a_flock), .freeahb_next (a_next_in),
      .freeahb_rdata (freeahb_rdata), .freeahb_ready (freeahb_ready), .bus_err (a_bus_err)
   );

   picorv32_freeahb_bridge #(
      .MERGE_STROBES  (0),
      .TIMEOUT_CYCLES (8)
   ) dut_b (
      .clk (clk), .reset (reset),
      .mem_valid (b_valid_in), .mem_instr (mem_instr), .mem_ready (b_mem_ready),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_wstrb (mem_wstrb),
      .mem_rdata (b_mem_rdata), .freeahb_wdata (b_fwdata), .freeahb_valid (b_fvalid),
      .freeahb_addr (b_faddr), .freeahb_size (b_fsize), .freeahb_write (b_fwrite),
      .freeahb_read (b_fread), .freeahb_min_len (b_fmin_len), .freeahb_cont (b_fcont),
      .freeahb_prot (b_fprot), .freeahb_lock (b_flock), .freeahb_next (b_next_in),
      .freeahb_rdata (freeahb_rdata), .freeahb_ready (freeahb_ready), .bus_err (b_bus_err)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic instr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
      mem_valid = valid;
      mem_instr = instr;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic doReset;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      next_drv      = 1'b0;
      freeahb_ready = 1'b0;
      reset         = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_valid"},  32'(obs_valid), 32'd0);
      checkOutput({tag, "_write"},  32'(obs_write), 32'd0);
      checkOutput({tag, "_read"},   32'(obs_read), 32'd0);
      checkOutput({tag, "_ready"},  32'(obs_mem_ready), 32'd0);
      checkOutput({tag, "_size"},   32'(obs_size), 32'h2);
      checkOutput({tag, "_prot"},   32'(obs_prot), 32'h1);
      checkOutput({tag, "_addr"},   obs_addr, 32'd0);
      checkOutput({tag, "_minlen"}, obs_min_len, 32'd0);
      checkOutput({tag, "_wdata"},  obs_wdata, 32'd0);
   endtask

   initial begin
      int n;
      int pulses;

      // Reset values on the default instance.
      sel = 1'b0;
      doReset();
      checkIdleOutputs("rst");
      checkOutput("rst_rdata", a_mem_rdata, 32'd0);
      checkOutput("rst_buserr", 32'(a_bus_err), 32'd0);
      checkOutput("rst_contlock", {30'd0, a_fcont, a_flock}, 32'd0);

      // Read with a 2-cycle acceptance delay; mem_valid stays high throughout.
      applyStimulus(1'b1, 1'b0, 32'h4000_0010, 32'd0, 4'd0);
      tick();
      checkOutput("rd_valid",  32'(obs_valid), 32'd1);
      checkOutput("rd_read",   32'(obs_read), 32'd1);
      checkOutput("rd_write",  32'(obs_write), 32'd0);
      checkOutput("rd_addr",   obs_addr, 32'h4000_0010);
      checkOutput("rd_size",   32'(obs_size), 32'h2);
      checkOutput("rd_minlen", obs_min_len, 32'd32);
      checkOutput("rd_prot",   32'(obs_prot), 32'h1);
      tick();
      checkOutput("rd_held", 32'(obs_valid), 32'd1);
      next_drv = 1'b1;
      tick();
      next_drv = 1'b0;
      checkOutput("rd_wait_valid", 32'(obs_valid), 32'd0);
      checkOutput("rd_wait_ready", 32'(obs_mem_ready), 32'd0);
      tick();
      freeahb_rdata = 32'h1234_5678;
      freeahb_ready = 1'b1;
      tick();
      freeahb_ready = 1'b0;
      freeahb_rdata = 32'h0;
      checkOutput("rd_done_ready", 32'(obs_mem_ready), 32'd1);
      checkOutput("rd_rdata", obs_mem_rdata, 32'h1234_5678);
      n = 0;
      pulses = 0;
      do begin
         tick();
         n++;
         if (obs_mem_ready) pulses++;
      end while (!obs_valid && n < 20);
      checkOutput("hold_gap", 32'(n), 32'd6);
      checkOutput("hold_ready_pulses", 32'(pulses), 32'd0);
      checkOutput("rd_rdata_kept", obs_mem_rdata, 32'h1234_5678);

      // Full-word write.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'hA1B2_C3D4, 4'hF);
      tick();
      mem_valid = 1'b0;
      checkOutput("ww_valid",  32'(obs_valid), 32'd1);
      checkOutput("ww_write",  32'(obs_write), 32'd1);
      checkOutput("ww_read",   32'(obs_read), 32'd0);
      checkOutput("ww_addr",   obs_addr, 32'h0000_0100);
      checkOutput("ww_size",   32'(obs_size), 32'h2);
      checkOutput("ww_minlen", obs_min_len, 32'd32);
      checkOutput("ww_wdata",  obs_wdata, 32'hA1B2_C3D4);
      next_drv = 1'b1;
      tick();
      checkOutput("ww_drain_valid", 32'(obs_valid), 32'd0);
      checkOutput("ww_drain_write", 32'(obs_write), 32'd0);
      tick();
      next_drv = 1'b0;
      checkOutput("ww_done_ready", 32'(obs_mem_ready), 32'd1);
      tick();
      checkOutput("ww_ready_once", 32'(obs_mem_ready), 32'd0);

      // Big-endian 1011 merged: byte at +0 then halfword at +2; inputs change mid-way.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h1122_3344, 4'b1011);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0000_0999, 32'hFFFF_FFFF, 4'hF);
      checkOutput("bm_p0_addr",   obs_addr, 32'h0000_0200);
      checkOutput("bm_p0_size",   32'(obs_size), 32'h0);
      checkOutput("bm_p0_minlen", obs_min_len, 32'd8);
      checkOutput("bm_p0_wdata",  obs_wdata, 32'h1122_3344);
      next_drv = 1'b1;
      tick();
      checkOutput("bm_p1_valid",  32'(obs_valid), 32'd1);
      checkOutput("bm_p1_addr",   obs_addr, 32'h0000_0202);
      checkOutput("bm_p1_size",   32'(obs_size), 32'h1);
      checkOutput("bm_p1_minlen", obs_min_len, 32'd16);
      tick();
      checkOutput("bm_drain_valid", 32'(obs_valid), 32'd0);
      tick();
      next_drv = 1'b0;
      checkOutput("bm_done_ready", 32'(obs_mem_ready), 32'd1);

      // Reset while the second piece is presented.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h1122_3344, 4'b1011);
      tick();
      mem_valid = 1'b0;
      next_drv = 1'b1;
      tick();
      checkOutput("rm_p1_addr", obs_addr, 32'h0000_0202);
      reset = 1'b1;
      next_drv = 1'b0;
      tick();
      checkIdleOutputs("rm");
      reset = 1'b0;
      tick();
      checkOutput("rm_after_ready", 32'(obs_mem_ready), 32'd0);
      tick();
      checkOutput("rm_after_ready2", 32'(obs_mem_ready), 32'd0);
      checkOutput("rm_after_valid", 32'(obs_valid), 32'd0);

      // Unmerged instance: three byte writes at +0, +2, +3.
      sel = 1'b1;
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h1122_3344, 4'b1011);
      tick();
      mem_valid = 1'b0;
      checkOutput("nm_p0_addr", obs_addr, 32'h0000_0200);
      checkOutput("nm_p0_size", 32'(obs_size), 32'h0);
      next_drv = 1'b1;
      tick();
      checkOutput("nm_p1_addr", obs_addr, 32'h0000_0202);
      checkOutput("nm_p1_size", 32'(obs_size), 32'h0);
      tick();
      checkOutput("nm_p2_addr",   obs_addr, 32'h0000_0203);
      checkOutput("nm_p2_size",   32'(obs_size), 32'h0);
      checkOutput("nm_p2_minlen", obs_min_len, 32'd8);
      tick();
      checkOutput("nm_drain_valid", 32'(obs_valid), 32'd0);
      tick();
      next_drv = 1'b0;
      checkOutput("nm_done_ready", 32'(obs_mem_ready), 32'd1);

      // Timeout: instruction read never accepted.
      doReset();
      applyStimulus(1'b1, 1'b1, 32'h0000_0300, 32'd0, 4'd0);
      tick();
      mem_valid = 1'b0;
      checkOutput("to_valid", 32'(obs_valid), 32'd1);
      checkOutput("to_prot",  32'(obs_prot), 32'h0);
      n = 0;
      while (!obs_mem_ready && n < 20) begin
         tick();
         n++;
      end
      checkOutput("to_cycles", 32'(n), 32'd8);
      checkOutput("to_rdata",  obs_mem_rdata, 32'hDEAD_BEEF);
      checkOutput("to_buserr", 32'(obs_bus_err), 32'd1);
      checkOutput("to_valid_dropped", 32'(obs_valid), 32'd0);
      for (int i = 0; i < 8; i++) tick();
      checkOutput("to_buserr_sticky", 32'(obs_bus_err), 32'd1);
      checkOutput("to_idle_ready", 32'(obs_mem_ready), 32'd0);
      doReset();
      checkOutput("to_buserr_cleared", 32'(obs_bus_err), 32'd0);
      checkOutput("to_rdata_cleared", obs_mem_rdata, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/picorv32_freeahb_bridge.md
PICORV32_FREEAHB_BRIDGE -- requirements
Module: picorv32_freeahb_bridge

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1; 1: wstrb[3]/wdata[31:24] is byte at addr+0, 0: wstrb[0]/wdata[7:0] is byte at addr+0.
REQ-002 SHALL have parameter MERGE_STROBES, default 1; 1: merge strobes into largest aligned pieces, 0: one byte transfer per set strobe.
REQ-003 SHALL have parameter WDATA_RALIGN, default 0; 0: freeahb_wdata = mem_wdata (lane-correct), 1: piece right-aligned into low bits.
REQ-004 SHALL have parameter HOLD_CYCLES, default 4; idle cycles after mem_ready before a new request is sampled (range 1..15).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 0; wait-cycle limit per transfer, 0 disables.
REQ-006 SHALL have ports, clock and reset first: clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-007 SHALL have PicoRV32 ports: mem_valid in 1; mem_instr in 1; mem_ready out 1; mem_addr in 32; mem_wdata in 32; mem_wstrb in 4; mem_rdata out 32.
REQ-008 SHALL have FreeAHB ports: freeahb_wdata out 32; freeahb_valid out 1; freeahb_addr out 32; freeahb_size out 3; freeahb_write out 1; freeahb_read out 1; freeahb_min_len out 32; freeahb_cont out 1; freeahb_prot out 4; freeahb_lock out 1; freeahb_next in 1; freeahb_rdata in 32; freeahb_ready in 1.
REQ-009 SHALL have bus_err out 1: sticky timeout flag, cleared only by reset.

Function
REQ-010 SHALL use states IDLE, RD_REQ, RD_WAIT, WR_ISSUE, WR_DRAIN, DONE, HOLD.
REQ-011 In IDLE, mem_valid=1 SHALL latch addr/wdata/wstrb/instr and go to RD_REQ (wstrb=0) or WR_ISSUE (wstrb!=0) on the next cycle.
REQ-012 Read: freeahb_valid=1, read=1, size=3'b010, min_len=32, addr=mem_addr, held until freeahb_next=1 (accept), then valid=0 and go to RD_WAIT.
REQ-013 RD_WAIT: on freeahb_ready=1 SHALL register freeahb_rdata into mem_rdata and go to DONE; mem_rdata is registered, not combinational.
REQ-014 Write split, MERGE_STROBES=1: 1111 -> one word; byte-lane pairs {0,1} or {2,3} -> aligned halfword; remaining lanes -> bytes; pieces issued in ascending address order.
REQ-015 Each piece: valid=1, write=1, size 000/001/010, min_len 8/16/32, addr = line address + byte offset per BIG_ENDIAN; piece accepted on freeahb_valid=1 and freeahb_next=1, next piece presented the following cycle.
REQ-016 After last piece accepted: valid=0, go to WR_DRAIN; on freeahb_next=1 go to DONE.
REQ-017 freeahb_cont=0 and freeahb_lock=0 always; freeahb_prot = mem_instr ? 4'b0000 : 4'b0001.
REQ-018 DONE: mem_ready=1 for exactly one cycle, then HOLD for HOLD_CYCLES cycles with mem_valid ignored, then IDLE.
REQ-019 mem_valid or mem_wstrb changing mid-transaction SHALL be ignored; latched values complete.
REQ-020 Timeout: if TIMEOUT_CYCLES>0 and RD_REQ/RD_WAIT/WR_ISSUE/WR_DRAIN dwell reaches TIMEOUT_CYCLES, SHALL drop valid, set bus_err, load mem_rdata=32'hDEADBEEF and go to DONE.
REQ-021 freeahb_read/freeahb_write SHALL be 0 outside their transfer states.

Reset
REQ-022 Reset SHALL act on the clk edge, override all states including mid-transfer, and force IDLE.
REQ-023 Reset SHALL zero all outputs except freeahb_size=3'b010 and freeahb_prot=4'b0001, clear counters and bus_err; FreeAHB transfer in flight is abandoned.

Structure
REQ-024 Package picorv32_freeahb_pkg SHALL hold size encodings, prot constants, the state encoding and the 32'hDEADBEEF error value.
REQ-025 Sub-module picorv32_wstrb_splitter SHALL map (wstrb, piece index, BIG_ENDIAN, MERGE_STROBES) to piece offset, size, lane mask and last flag, purely combinationally.

Verification
REQ-026 Read 0x4000_0010, next after 2 cycles, ready with 0x1234_5678 -> one read, mem_rdata=0x1234_5678, one-cycle mem_ready, then 4 hold cycles.
REQ-027 Write wstrb=1111, MERGE=1 -> single word write to 0x100, size 010.
REQ-028 Write wstrb=1011, BIG_ENDIAN=1, addr 0x200 -> byte 0x200, then halfword 0x202; MERGE=0 -> bytes 0x200, 0x202, 0x203.
REQ-029 TIMEOUT_CYCLES=8, freeahb_next held 0 -> mem_ready at cycle 8 of wait, mem_rdata=0xDEADBEEF, bus_err=1 until reset.
REQ-030 Reset asserted during second write piece -> next cycle IDLE, all outputs at reset values, no mem_ready.
REQ-031 mem_valid held 1 across mem_ready -> no new request until HOLD_CYCLES elapsed.
